// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, byte width
// and the requester-index width helper.
package uart_tx_arbiter_pkg;

   localparam int UART_DW = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } arb_state_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or above ptr,
// wrapping explicitly at NUM_REQ-1 so non-power-of-two counts work.
module rr_pick
   import uart_tx_arbiter_pkg::*;
#(
   parameter int  NUM_REQ = 4,
   localparam int IDW     = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     ptr,
   output logic               hit,
   output logic [IDW-1:0]     idx
);

   int cand;

   always_comb begin
      hit  = 1'b0;
      idx  = '0;
      cand = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(ptr) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!hit && req[cand]) begin
            hit = 1'b1;
            idx = IDW'(cand);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// sources, with per-message lock bounded by MAX_BURST bytes.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int  NUM_REQ      = 4,
   parameter int  MAX_BURST    = 16,
   parameter int  BUSY_TIMEOUT = 8,
   localparam int IDW          = id_width(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [UART_DW*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ack,
   output logic [UART_DW-1:0]         tx_data,
   output logic                       tx_en,
   input  logic                       tx_ready,
   output logic                       busy,
   output logic [IDW-1:0]             grant_id,
   output logic                       timeout_err
);

   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int TW = $clog2(BUSY_TIMEOUT + 1);

   arb_state_t         state, state_n;
   logic [UART_DW-1:0] tx_data_n;
   logic               tx_en_n, last_q, last_n, terr_n;
   logic               lock, lock_n;
   logic [NUM_REQ-1:0] ack_n;
   logic [IDW-1:0]     grant_n, rr_ptr, rr_n;
   logic [BW-1:0]      burst_cnt, burst_n;
   logic [TW-1:0]      to_cnt, to_n;
   logic               pick_hit, sel_hit;
   logic [IDW-1:0]     pick_idx, sel_idx;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req (req_valid),
      .ptr (rr_ptr),
      .hit (pick_hit),
      .idx (pick_idx)
   );

   assign busy = (state != IDLE);

   always_comb begin
      state_n   = state;
      tx_data_n = tx_data;
      tx_en_n   = tx_en;
      last_n    = last_q;
      ack_n     = '0;
      grant_n   = grant_id;
      rr_n      = rr_ptr;
      lock_n    = lock;
      burst_n   = burst_cnt;
      to_n      = to_cnt;
      terr_n    = 1'b0;
      sel_hit   = pick_hit;
      sel_idx   = pick_idx;
      case (state)
         IDLE: begin
            // A locked owner keeps the channel only while it still has a byte ready.
            if (lock && req_valid[grant_id]) begin
               sel_hit = 1'b1;
               sel_idx = grant_id;
            end else begin
               lock_n  = 1'b0;
               burst_n = '0;
            end
            if (sel_hit) begin
               tx_data_n = req_data[int'(sel_idx)*UART_DW +: UART_DW];
               last_n    = req_last[sel_idx];
               grant_n   = sel_idx;
               tx_en_n   = 1'b1;
               state_n   = ISSUE;
            end
         end
         ISSUE: begin
            if (tx_ready) begin
               tx_en_n          = 1'b0;
               ack_n[grant_id]  = 1'b1;
               rr_n             = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
               if (!last_q && (int'(burst_cnt) + 1 < MAX_BURST)) begin
                  lock_n  = 1'b1;
                  burst_n = burst_cnt + 1'b1;
               end else begin
                  lock_n  = 1'b0;
                  burst_n = '0;
               end
               to_n    = '0;
               state_n = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (!tx_ready) begin
               state_n = WAIT_DONE;
            end else if (int'(to_cnt) == BUSY_TIMEOUT - 1) begin
               terr_n  = 1'b1;
               lock_n  = 1'b0;
               burst_n = '0;
               state_n = IDLE;
            end else begin
               to_n = to_cnt + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (tx_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         tx_data     <= '0;
         tx_en       <= 1'b0;
         last_q      <= 1'b0;
         req_ack     <= '0;
         grant_id    <= '0;
         rr_ptr      <= '0;
         lock        <= 1'b0;
         burst_cnt   <= '0;
         to_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_n;
         tx_data     <= tx_data_n;
         tx_en       <= tx_en_n;
         last_q      <= last_n;
         req_ack     <= ack_n;
         grant_id    <= grant_n;
         rr_ptr      <= rr_n;
         lock        <= lock_n;
         burst_cnt   <= burst_n;
         to_cnt      <= to_n;
         timeout_err <= terr_n;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requesters, a UART stub, and a handshake-level
// reference model compared against the DUT every cycle.
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int MB = 4;
   localparam int BT = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0]   req_last = '0;
   logic [N-1:0]   req_ack;
   logic [7:0]     tx_data;
   logic           tx_en;
   logic           tx_ready = 1'b1;
   logic           busy;
   logic [1:0]     grant_id;
   logic           timeout_err;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .BUSY_TIMEOUT(BT)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ack     (req_ack),
      .tx_data     (tx_data),
      .tx_en       (tx_en),
      .tx_ready    (tx_ready),
      .busy        (busy),
      .grant_id    (grant_id),
      .timeout_err (timeout_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: state of the shared channel as seen from its handshakes.
   localparam int M_IDLE = 0, M_ISSUE = 1, M_WB = 2, M_WD = 3;
   int         ph = M_IDLE, rr = 0, lock_own = -1, burst = 0, wcnt = 0, exp_g = 0;
   logic [7:0] exp_d = '0;
   logic       exp_last = 1'b0;
   logic       rst_s = 1'b1, rdy_s = 1'b0;
   logic [N-1:0]   vld_s = '0, last_s = '0;
   logic [8*N-1:0] data_s = '0;
   int         ackcnt [N] = '{default: 0};
   int         tocnt = 0;
   int         glog [$];
   int         gdata [$];

   always @(negedge clk) begin
      logic [N-1:0] exp_ack;
      logic         exp_to;
      int           win;
      exp_ack = '0;
      exp_to  = 1'b0;
      win     = -1;
      if (rst_s) begin
         ph = M_IDLE; rr = 0; lock_own = -1; burst = 0; wcnt = 0; exp_g = 0;
         chk("rst_tx_data", int'(tx_data), 0);
      end else begin
         case (ph)
            M_IDLE: begin
               if (lock_own >= 0 && vld_s[lock_own]) win = lock_own;
               else begin
                  lock_own = -1;
                  burst    = 0;
                  for (int k = 0; k < N; k++)
                     if (win < 0 && vld_s[(rr + k) % N]) win = (rr + k) % N;
               end
               if (win >= 0) begin
                  exp_g    = win;
                  exp_d    = data_s[8*win +: 8];
                  exp_last = last_s[win];
                  glog.push_back(win);
                  gdata.push_back(int'(exp_d));
                  ph = M_ISSUE;
               end
            end
            M_ISSUE: if (rdy_s) begin
               exp_ack[exp_g] = 1'b1;
               rr    = (exp_g + 1) % N;
               burst = burst + 1;
               if (!exp_last && burst < MB) lock_own = exp_g;
               else begin
                  lock_own = -1;
                  burst    = 0;
               end
               wcnt = 0;
               ph   = M_WB;
            end
            M_WB: begin
               if (!rdy_s) ph = M_WD;
               else begin
                  wcnt = wcnt + 1;
                  if (wcnt == BT) begin
                     exp_to   = 1'b1;
                     lock_own = -1;
                     burst    = 0;
                     ph       = M_IDLE;
                  end
               end
            end
            default: if (rdy_s) ph = M_IDLE;
         endcase
      end
      chk("tx_en", int'(tx_en), int'(ph == M_ISSUE));
      chk("busy", int'(busy), int'(ph != M_IDLE));
      chk("req_ack", int'(req_ack), int'(exp_ack));
      chk("timeout_err", int'(timeout_err), int'(exp_to));
      chk("grant_id", int'(grant_id), exp_g);
      if (ph == M_ISSUE) chk("tx_data", int'(tx_data), int'(exp_d));
      for (int i = 0; i < N; i++) if (req_ack[i]) ackcnt[i]++;
      if (timeout_err) tocnt++;
      rst_s  = rst;
      vld_s  = req_valid;
      data_s = req_data;
      last_s = req_last;
      rdy_s  = tx_ready;
   end

   // Requester queues ({last, data}) and UART stub, advanced once per clock.
   logic [8:0] q [N][$];
   logic       en_then = 1'b0, rdy_then = 1'b0;
   int         hold = 0, low = 0;
   bit         post = 0, rand_mode = 0, force_to = 0, force_low = 0, rdy_idle_val = 1;

   task automatic present();
      logic [8:0] h;
      for (int i = 0; i < N; i++) begin
         h = (q[i].size() > 0) ? q[i][0] : 9'h0;
         req_valid[i]      = (q[i].size() > 0);
         req_data[8*i +: 8] = h[7:0];
         req_last[i]       = h[8];
      end
   endtask

   task automatic step();
      bit acc, rst_b;
      int r, len;
      rst_b = rst;
      @(posedge clk);
      #1;
      acc = en_then && rdy_then && !rst_b;
      for (int i = 0; i < N; i++)
         if (req_ack[i] && q[i].size() > 0) void'(q[i].pop_front());
      if (acc) begin
         post = 1;
         if (force_to || (rand_mode && $urandom_range(15) == 0)) begin
            hold = BT + 2; low = 1; force_to = 0;
         end else if (force_low) begin
            hold = 0; low = 8; force_low = 0;
         end else begin
            hold = $urandom_range(2); low = $urandom_range(3, 1);
         end
      end
      if (post) begin
         if (hold > 0) begin tx_ready = 1'b1; hold--; end
         else if (low > 0) begin tx_ready = 1'b0; low--; end
         else begin tx_ready = 1'b1; post = 0; end
      end else begin
         tx_ready = rand_mode ? ($urandom_range(5) != 0) : rdy_idle_val;
      end
      if (rand_mode && $urandom_range(9) == 0) begin
         r = $urandom_range(N - 1);
         if (q[r].size() < 6) begin
            len = $urandom_range(5, 1);
            for (int j = 0; j < len; j++) q[r].push_back({(j == len - 1), 8'($urandom)});
         end
      end
      present();
      en_then  = tx_en;
      rdy_then = tx_ready;
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < N; i++) if (q[i].size() != 0) return 0;
      return 1;
   endfunction

   task automatic drain(input string nm, input int limit);
      int n = 0, quiet = 0;
      while (quiet < 3 && n < limit) begin
         step();
         n++;
         if (all_empty() && !busy && !tx_en) quiet++;
         else quiet = 0;
      end
      chk({nm, "_drained"}, int'(quiet >= 3), 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic chk_order(input string nm, input int base, input int len, input logic [31:0] seq);
      chk({nm, "_count"}, glog.size() - base, len);
      for (int k = 0; k < len; k++)
         chk({nm, "_grant"}, glog[base + k], int'((seq >> (4 * (len - 1 - k))) & 32'hF));
   endtask

   initial begin
      int base, a0, a1, a2, a3, t0;
      step();
      step();
      chk("reset_tx_en", int'(tx_en), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_grant", int'(grant_id), 0);
      chk("reset_ack", int'(req_ack), 0);
      rst = 1'b0;

      // Single requester, single byte
      base = glog.size(); a0 = ackcnt[0];
      q[0].push_back({1'b1, 8'h55});
      drain("single", 100);
      chk_order("single", base, 1, 32'h0);
      chk("single_data", gdata[base], 8'h55);
      chk("single_ack", ackcnt[0] - a0, 1);

      // All four valid, requester 0 has a second byte
      do_reset();
      base = glog.size(); a0 = ackcnt[0]; a1 = ackcnt[1]; a2 = ackcnt[2]; a3 = ackcnt[3];
      q[0].push_back({1'b1, 8'hA0}); q[0].push_back({1'b1, 8'hB0});
      q[1].push_back({1'b1, 8'hA1});
      q[2].push_back({1'b1, 8'hA2});
      q[3].push_back({1'b1, 8'hA3});
      drain("rr4", 300);
      chk_order("rr4", base, 5, 32'h01230);
      chk("rr4_data1", gdata[base + 1], 8'hA1);
      chk("rr4_data4", gdata[base + 4], 8'hB0);
      chk("rr4_ack0", ackcnt[0] - a0, 2);
      chk("rr4_ack3", ackcnt[3] - a3, 1);

      // Message lock: three-byte message from 0 ahead of waiting requester 1
      do_reset();
      base = glog.size();
      q[0].push_back({1'b0, 8'h10}); q[0].push_back({1'b0, 8'h11}); q[0].push_back({1'b1, 8'h12});
      q[1].push_back({1'b1, 8'h20});
      drain("lock", 300);
      chk_order("lock", base, 4, 32'h0001);

      // Burst limit of MB bytes forces a handover mid-message
      do_reset();
      base = glog.size();
      for (int j = 0; j < 5; j++) q[0].push_back({(j == 4), 8'(8'h60 + j)});
      q[1].push_back({1'b1, 8'h70});
      drain("burst", 400);
      chk_order("burst", base, 6, 32'h000010);

      // UART never drops ready: timeout, then rotation to requester 1
      do_reset();
      base = glog.size(); a0 = ackcnt[0]; t0 = tocnt;
      force_to = 1;
      q[0].push_back({1'b1, 8'h30});
      q[1].push_back({1'b1, 8'h31});
      drain("timeout", 300);
      chk_order("timeout", base, 2, 32'h01);
      chk("timeout_pulses", tocnt - t0, 1);
      chk("timeout_ack0", ackcnt[0] - a0, 1);

      // Reset while waiting for accept: no ack, byte re-granted afterwards
      do_reset();
      base = glog.size(); a2 = ackcnt[2];
      rdy_idle_val = 0;
      q[2].push_back({1'b1, 8'h40});
      repeat (5) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_issue_ack", ackcnt[2] - a2, 0);
      rdy_idle_val = 1;
      drain("rst_issue", 200);
      chk_order("rst_issue", base, 2, 32'h22);
      chk("rst_issue_ack_total", ackcnt[2] - a2, 1);

      // Reset while the UART is busy (after ack), remaining byte re-granted
      do_reset();
      base = glog.size(); a3 = ackcnt[3];
      force_low = 1;
      q[3].push_back({1'b0, 8'h50}); q[3].push_back({1'b1, 8'h51});
      for (int k = 0; k < 20 && ackcnt[3] == a3; k++) step();
      chk("rst_wd_first_ack", ackcnt[3] - a3, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_wd_tx_en", int'(tx_en), 0);
      chk("rst_wd_busy", int'(busy), 0);
      chk("rst_wd_grant", int'(grant_id), 0);
      chk("rst_wd_ack", int'(req_ack), 0);
      drain("rst_wd", 200);
      chk_order("rst_wd", base, 2, 32'h33);
      chk("rst_wd_data", gdata[base + 1], 8'h51);
      chk("rst_wd_ack_total", ackcnt[3] - a3, 2);

      // Randomized traffic, UART timing and occasional resets
      rand_mode = 1;
      for (int k = 0; k < 4000; k++) begin
         rst = ($urandom_range(499) == 0);
         step();
      end
      rst = 1'b0;
      rand_mode = 0;
      drain("random", 2000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
